branch_target_buffer: RTL
=========================

// Module: branch_target_buffer
// PURPOSE
//  IF-stage producer of the btb_hit/btb_target prediction carried down the pipeline, and EX-stage consumer of it.
//  Direct-mapped BTB with 2-bit saturating counters.
//  IF side: combinational lookup on the fetch PC.
//  EX side: compares the carried prediction with the resolved outcome, drives mispredict/redirect to the hazard unit, and updates the table.
// PARAMETERS
//  ENTRIES  16  table depth; power of 2, >=2
//  IDX_W    $clog2(ENTRIES)  localparam; index = pc[IDX_W+1:2]
//  TAG_W    30-IDX_W  localparam; tag = pc[31:IDX_W+2]
// PORTS
//  clk           in   1   clock; table and counters update on rising edge
//  rst           in   1   reset; asynchronous, active-high
//  invalidate    in   1   clear all valid bits (fence.i)
//  pcF           in   32  fetch PC
//  btb_hitF      out  1   predict taken
//  btb_targetF   out  32  predicted target (0 when btb_hitF=0)
//  updateE       in   1   valid (non-bubble) instruction in EX
//  pcE           in   32  EX instruction PC
//  branchE       in   1   EX instruction is a conditional branch
//  jumpE         in   1   EX instruction is a JAL (JALR is never stored)
//  takenE        in   1   resolved taken (branch taken, or any jump)
//  targetE       in   32  resolved target
//  btb_hitE      in   1   prediction carried from IF
//  btb_targetE   in   32  predicted target carried from IF
//  mispredictE   out  1   redirect request to the hazard unit
//  correct_pcE   out  32  redirect PC
//  hit_count     out  32  perf: updates with btb_hitE=1
//  mispred_count out  32  perf: cycles with mispredictE=1
// BEHAVIOUR
//  - Entry = {valid, tag, target, ctr[1:0]}. Counter states: SNT=00, WNT=01, WT=10, ST=11.
//  - Lookup (comb):
//    - btb_hitF = valid && tag match && ctr[1].
//    - Reads see pre-edge state; no bypass from a same-cycle update.
//  - mispredictE (comb) = updateE && (takenE != btb_hitE || (takenE && btb_targetE != targetE)).
//  - correct_pcE = takenE ? targetE : pcE+32'd4 (mod 2^32). Meaningful only when mispredictE=1.
//  - Update at rising edge, when updateE=1:
//    - branchE, entry hit: ctr sat-inc if taken, sat-dec if not (ST and SNT saturate); target<=targetE if taken.
//    - branchE, miss, taken: allocate/replace; tag, target, ctr<=WT, valid<=1.
//    - branchE, miss, not taken: no change.
//    - jumpE (JAL): allocate/overwrite; ctr<=ST, target<=targetE.
//    - Neither branchE nor jumpE, with btb_hitE=1 (stale entry): mispredictE=1, correct_pcE=pcE+4, clear valid of pcE's index.
//    - updateE=0: no table change, no counter increment.
//  - invalidate:
//    - Clears every valid bit at the edge; has priority over a same-cycle update.
//    - Perf counters untouched.
//  - Perf counters wrap at 2^32.
//  - rst, asynchronous, mid-operation included: all valid<=0, ctr<=SNT, hit_count=mispred_count=0.
//    - Hence btb_hitF=0, btb_targetF=0 immediately; mispredictE follows its inputs.
//  - No stall input: lookup is combinational; the caller gates updateE during stalls/bubbles.
// STRUCTURE
//  - btb_pkg:
//    - ctr_t enum (SNT/WNT/WT/ST)
//    - btb_entry_t struct
//    - function ctr_next(ctr_t, logic taken)
//    - localparam ALLOC_BRANCH=WT, ALLOC_JAL=ST
//  - One sub-module, btb_storage:
//    - valid/tag/target/ctr arrays
//    - 1 async read port, 1 sync write port
//    - single-index clear, global invalidate
//  - Mispredict compare and perf counters live in the top.
// TESTING (ENTRIES=16: idx=pc[5:2], tag=pc[31:6])
//  1. Reset: after rst pulse, pcF=0x100 -> btb_hitF=0, btb_targetF=0, hit_count=0, mispred_count=0.
//  2. Cold taken branch: updateE, branchE, takenE, pcE=0x100, targetE=0x80, btb_hitE=0
//     -> mispredictE=1, correct_pcE=0x80; next cycle pcF=0x100 -> btb_hitF=1, btb_targetF=0x80; mispred_count=1.
//  3. Hysteresis from (2): not-taken at 0x100 with btb_hitE=1 -> mispredictE=1, correct_pcE=0x104, ctr=WNT, hitF=0;
//     then taken -> ctr=WT, hitF=1 again; four taken -> ctr stays ST.
//  4. Alias: taken at 0x140 (same idx 0, new tag), target 0x200 -> pcF=0x100 misses; pcF=0x140 hits, btb_targetF=0x200.
//  5. Same-cycle update+lookup, pcF=pcE=0x100 on cold entry: btb_hitF=0 that cycle, 1 the next.
//     JAL at 0x10C target 0x40 -> ctr=ST, hit next cycle.
//  6. Invalidate and stale entry:
//     - invalidate -> all lookups miss, perf counters unchanged.
//     - Non-branch at 0x10C with btb_hitE=1 -> mispredictE=1, correct_pcE=0x110, entry cleared.
//     - rst asserted mid-sequence -> outputs zero before the next clk edge.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types for the branch target buffer: counter encoding, table entry
// layout and the saturating-counter step function.
package btb_pkg;

  localparam int unsigned XLEN      = 32;
  // Widest tag for the smallest legal table (2 entries); narrower tags are zero-extended.
  localparam int unsigned TAG_MAX_W = 29;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [XLEN-1:0]      target;
    ctr_t                 ctr;
  } btb_entry_t;

  localparam ctr_t ALLOC_BRANCH = WT;
  localparam ctr_t ALLOC_JAL    = ST;

  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    case (c)
      SNT:     return taken ? WNT : SNT;
      WNT:     return taken ? WT  : SNT;
      WT:      return taken ? ST  : WNT;
      ST:      return taken ? ST  : WT;
      default: return SNT;
    endcase
  endfunction

  function automatic logic [TAG_MAX_W-1:0] pc_tag(input logic [XLEN-1:0] pc,
                                                  input int unsigned idx_w);
    return TAG_MAX_W'(pc >> (idx_w + 2));
  endfunction

endpackage

// File: rtl/btb_if.sv
// Fetch-side lookup, execute-side resolution and perf-counter signals of the BTB.
interface btb_if;
  import btb_pkg::*;

  logic            invalidate;
  logic [XLEN-1:0] pcF;
  logic            btb_hitF;
  logic [XLEN-1:0] btb_targetF;
  logic            updateE;
  logic [XLEN-1:0] pcE;
  logic            branchE;
  logic            jumpE;
  logic            takenE;
  logic [XLEN-1:0] targetE;
  logic            btb_hitE;
  logic [XLEN-1:0] btb_targetE;
  logic            mispredictE;
  logic [XLEN-1:0] correct_pcE;
  logic [31:0]     hit_count;
  logic [31:0]     mispred_count;

  modport master (
    output invalidate, pcF, updateE, pcE, branchE, jumpE, takenE, targetE,
           btb_hitE, btb_targetE,
    input  btb_hitF, btb_targetF, mispredictE, correct_pcE, hit_count, mispred_count
  );

  modport slave (
    input  invalidate, pcF, updateE, pcE, branchE, jumpE, takenE, targetE,
           btb_hitE, btb_targetE,
    output btb_hitF, btb_targetF, mispredictE, correct_pcE, hit_count, mispred_count
  );
endinterface

// File: rtl/btb_storage.sv
// Direct-mapped BTB table: one async read port, one read-modify-write update
// port, single-index valid clear and global invalidate.
module btb_storage
  import btb_pkg::*;
#(
  parameter  int unsigned ENTRIES = 16,
  localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_invalidate,
  input  logic [IDX_W-1:0]     i_rd_idx,
  output btb_entry_t           o_rd_entry,
  input  logic                 i_wr_en,
  input  logic [IDX_W-1:0]     i_wr_idx,
  input  logic [TAG_MAX_W-1:0] i_wr_tag,
  input  logic [XLEN-1:0]      i_wr_target,
  input  logic                 i_wr_jal,
  input  logic                 i_wr_taken,
  input  logic                 i_clr_en,
  input  logic [IDX_W-1:0]     i_clr_idx
);

  btb_entry_t r_mem [ENTRIES];

  btb_entry_t w_cur;
  btb_entry_t w_next;
  logic       w_we;
  logic       w_hit;

  assign o_rd_entry = r_mem[i_rd_idx];

  // Next value of the entry addressed by the update port.
  always_comb begin
    w_cur  = r_mem[i_wr_idx];
    w_hit  = w_cur.valid && (w_cur.tag == i_wr_tag);
    w_next = w_cur;
    w_we   = 1'b0;
    if (i_wr_en) begin
      if (i_wr_jal) begin
        w_next = '{valid: 1'b1, tag: i_wr_tag, target: i_wr_target, ctr: ALLOC_JAL};
        w_we   = 1'b1;
      end else if (w_hit) begin
        w_next.ctr = ctr_next(w_cur.ctr, i_wr_taken);
        if (i_wr_taken) w_next.target = i_wr_target;
        w_we = 1'b1;
      end else if (i_wr_taken) begin
        w_next = '{valid: 1'b1, tag: i_wr_tag, target: i_wr_target, ctr: ALLOC_BRANCH};
        w_we   = 1'b1;
      end
    end
  end

  // Invalidate wins over any same-cycle update or clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_mem[i] <= '0;
    end else if (i_invalidate) begin
      for (int i = 0; i < ENTRIES; i++) r_mem[i].valid <= 1'b0;
    end else begin
      if (w_we)     r_mem[i_wr_idx]        <= w_next;
      if (i_clr_en) r_mem[i_clr_idx].valid <= 1'b0;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Branch target buffer: IF-stage taken prediction and EX-stage mispredict
// detection, redirect PC, table update and perf counters.
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int unsigned ENTRIES = 16
) (
  input logic  clk,
  input logic  rst,
  btb_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  logic [IDX_W-1:0]     w_idxF;
  logic [IDX_W-1:0]     w_idxE;
  logic [TAG_MAX_W-1:0] w_tagF;
  logic [TAG_MAX_W-1:0] w_tagE;
  btb_entry_t           w_entryF;
  logic                 w_hitF;
  logic                 w_mispredE;
  logic                 w_wr_en;
  logic                 w_clr_en;
  logic [31:0]          r_hit_count;
  logic [31:0]          r_mispred_count;

  assign w_idxF = bus.pcF[IDX_W+1:2];
  assign w_idxE = bus.pcE[IDX_W+1:2];
  assign w_tagF = pc_tag(bus.pcF, IDX_W);
  assign w_tagE = pc_tag(bus.pcE, IDX_W);

  btb_storage #(.ENTRIES(ENTRIES)) u_storage (
    .clk          (clk),
    .rst          (rst),
    .i_invalidate (bus.invalidate),
    .i_rd_idx     (w_idxF),
    .o_rd_entry   (w_entryF),
    .i_wr_en      (w_wr_en),
    .i_wr_idx     (w_idxE),
    .i_wr_tag     (w_tagE),
    .i_wr_target  (bus.targetE),
    .i_wr_jal     (bus.jumpE),
    .i_wr_taken   (bus.takenE),
    .i_clr_en     (w_clr_en),
    .i_clr_idx    (w_idxE)
  );

  assign w_hitF          = w_entryF.valid && (w_entryF.tag == w_tagF) && w_entryF.ctr[1];
  assign bus.btb_hitF    = w_hitF;
  assign bus.btb_targetF = w_hitF ? w_entryF.target : '0;

  assign w_mispredE = bus.updateE &&
                      ((bus.takenE != bus.btb_hitE) ||
                       (bus.takenE && (bus.btb_targetE != bus.targetE)));
  assign bus.mispredictE = w_mispredE;
  assign bus.correct_pcE = bus.takenE ? bus.targetE : (bus.pcE + 32'd4);

  // A predicted hit on a non-control instruction means the entry is stale.
  assign w_wr_en  = bus.updateE && (bus.branchE || bus.jumpE);
  assign w_clr_en = bus.updateE && !bus.branchE && !bus.jumpE && bus.btb_hitE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_count     <= '0;
      r_mispred_count <= '0;
    end else begin
      if (bus.updateE && bus.btb_hitE) r_hit_count <= r_hit_count + 32'd1;
      if (w_mispredE) r_mispred_count <= r_mispred_count + 32'd1;
    end
  end

  assign bus.hit_count     = r_hit_count;
  assign bus.mispred_count = r_mispred_count;

endmodule
